// File: rtl/data_mem_arbiter_pkg.sv
// Shared constants and the owner encoding used by the data memory arbiter
// and its read-tag pipeline.
package data_mem_arbiter_pkg;

  localparam int DM_ADDR_W = 9;
  localparam int DM_DATA_W = 32;
  localparam int DM_RD_LAT = 2;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_AUX  = 1'b1
  } owner_e;

endpackage

// File: rtl/dm_rd_tag_pipe.sv
// Read-tag shift register: one {valid, owner} entry per memory read-latency
// stage, so returning data can be steered to the port that issued the read.
module dm_rd_tag_pipe
  import data_mem_arbiter_pkg::*;
#(
  parameter int STAGES = DM_RD_LAT
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   vld_i,
  input  owner_e own_i,
  output logic   vld_o,
  output owner_e own_o
);

  logic [STAGES-1:0] vld_q;
  owner_e            own_q [STAGES];

  // Only the valid bits need clearing; an owner tag is ignored while invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= vld_i;
      for (int s = 1; s < STAGES; s++) begin
        vld_q[s] <= vld_q[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    own_q[0] <= own_i;
    for (int s = 1; s < STAGES; s++) begin
      own_q[s] <= own_q[s-1];
    end
  end

  assign vld_o = vld_q[STAGES-1];
  assign own_o = own_q[STAGES-1];

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for the single-port data memory: core port C normally wins,
// auxiliary port A is boosted after waiting too long; read data is tag-routed.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DM_ADDR_W,
  parameter int DATA_W     = DM_DATA_W,
  parameter int RD_LAT     = DM_RD_LAT,
  parameter int STARVE_LIM = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req_i,
  input  logic              c_we_i,
  input  logic [ADDR_W-1:0] c_addr_i,
  input  logic [DATA_W-1:0] c_din_i,
  output logic              c_gnt_o,
  output logic              c_rvalid_o,
  output logic [DATA_W-1:0] c_dout_o,
  input  logic              a_req_i,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_din_i,
  output logic              a_gnt_o,
  output logic              a_rvalid_o,
  output logic [DATA_W-1:0] a_dout_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_din_o,
  input  logic [DATA_W-1:0] mem_dout_i
);

  localparam int WAIT_W = (STARVE_LIM > 2) ? $clog2(STARVE_LIM) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIM - 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              boost_q, boost_d;
  logic              rd_issue;
  owner_e            rd_own;
  logic              tag_vld;
  owner_e            tag_own;

  always_comb begin
    c_gnt_o = 1'b0;
    a_gnt_o = 1'b0;
    if (!rst) begin
      if (boost_q) begin
        if (a_req_i)      a_gnt_o = 1'b1;
        else if (c_req_i) c_gnt_o = 1'b1;
      end else begin
        if (c_req_i)      c_gnt_o = 1'b1;
        else if (a_req_i) a_gnt_o = 1'b1;
      end
    end
  end

  // With no winner the address/data still follow C; only the write strobe matters.
  assign mem_we_o   = (c_gnt_o & c_we_i) | (a_gnt_o & a_we_i);
  assign mem_addr_o = a_gnt_o ? a_addr_i : c_addr_i;
  assign mem_din_o  = a_gnt_o ? a_din_i  : c_din_i;

  assign rd_issue = (c_gnt_o & ~c_we_i) | (a_gnt_o & ~a_we_i);
  assign rd_own   = a_gnt_o ? OWN_AUX : OWN_CORE;

  always_comb begin
    wait_d  = wait_q;
    boost_d = boost_q;
    if (a_gnt_o || !a_req_i) begin
      wait_d = '0;
    end else if (wait_q != WAIT_MAX) begin
      wait_d = wait_q + 1'b1;
    end
    if (a_gnt_o) begin
      boost_d = 1'b0;
    end else if (a_req_i && (wait_q == WAIT_MAX)) begin
      boost_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q  <= '0;
      boost_q <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      boost_q <= boost_d;
    end
  end

  dm_rd_tag_pipe #(
    .STAGES(RD_LAT)
  ) u_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .vld_i (rd_issue),
    .own_i (rd_own),
    .vld_o (tag_vld),
    .own_o (tag_own)
  );

  assign c_rvalid_o = tag_vld & (tag_own == OWN_CORE);
  assign a_rvalid_o = tag_vld & (tag_own == OWN_AUX);
  assign c_dout_o   = mem_dout_i;
  assign a_dout_o   = mem_dout_i;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed and random bench for data_mem_arbiter with a behavioural 2-cycle
// memory and a per-port scoreboard of expected read returns.
module tb_data_mem_arbiter;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              c_req_i, c_we_i, a_req_i, a_we_i;
  logic [ADDR_W-1:0] c_addr_i, a_addr_i;
  logic [DATA_W-1:0] c_din_i, a_din_i;
  logic              c_gnt_o, c_rvalid_o, a_gnt_o, a_rvalid_o;
  logic [DATA_W-1:0] c_dout_o, a_dout_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_din_o;
  logic [DATA_W-1:0] mem_r1, mem_r2;

  logic [DATA_W-1:0] mem    [512];
  logic [DATA_W-1:0] shadow [512];

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;
  exp_t cq[$];
  exp_t aq[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .c_req_i    (c_req_i),
    .c_we_i     (c_we_i),
    .c_addr_i   (c_addr_i),
    .c_din_i    (c_din_i),
    .c_gnt_o    (c_gnt_o),
    .c_rvalid_o (c_rvalid_o),
    .c_dout_o   (c_dout_o),
    .a_req_i    (a_req_i),
    .a_we_i     (a_we_i),
    .a_addr_i   (a_addr_i),
    .a_din_i    (a_din_i),
    .a_gnt_o    (a_gnt_o),
    .a_rvalid_o (a_rvalid_o),
    .a_dout_o   (a_dout_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_din_o  (mem_din_o),
    .mem_dout_i (mem_r2)
  );

  // Single-port memory: array read + output register, output holds on writes.
  always @(posedge clk) begin
    if (mem_we_o) mem[mem_addr_o] <= mem_din_o;
    else          mem_r1 <= mem[mem_addr_o];
    mem_r2 <= mem_r1;
  end

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: responses are compared before this cycle's grants are pushed.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    chk("two_gnt", 32'(c_gnt_o & a_gnt_o), 32'd0);
    if (rst) begin
      chk("rst_gnt", 32'({c_gnt_o, a_gnt_o, mem_we_o}), 32'd0);
    end
    if (c_rvalid_o === 1'b1) begin
      if (cq.size() == 0) begin
        chk("c_spurious", 32'd1, 32'd0);
      end else begin
        e = cq.pop_front();
        chk("c_data", c_dout_o, e.data);
        chk("c_lat", 32'(cyc), 32'(e.due));
      end
    end
    if (a_rvalid_o === 1'b1) begin
      if (aq.size() == 0) begin
        chk("a_spurious", 32'd1, 32'd0);
      end else begin
        e = aq.pop_front();
        chk("a_data", a_dout_o, e.data);
        chk("a_lat", 32'(cyc), 32'(e.due));
      end
    end
    if (cq.size() > 0 && cq[0].due < cyc) begin
      chk("c_lost", 32'(cyc), 32'(cq[0].due));
      void'(cq.pop_front());
    end
    if (aq.size() > 0 && aq[0].due < cyc) begin
      chk("a_lost", 32'(cyc), 32'(aq[0].due));
      void'(aq.pop_front());
    end
    if (rst) begin
      while (cq.size() > 0 && cq[$].due > cyc) void'(cq.pop_back());
      while (aq.size() > 0 && aq[$].due > cyc) void'(aq.pop_back());
    end
    if (c_gnt_o === 1'b1) begin
      if (c_we_i) shadow[c_addr_i] = c_din_i;
      else        cq.push_back('{data: shadow[c_addr_i], due: cyc + 2});
    end
    if (a_gnt_o === 1'b1) begin
      if (a_we_i) shadow[a_addr_i] = a_din_i;
      else        aq.push_back('{data: shadow[a_addr_i], due: cyc + 2});
    end
  end

  task automatic drive_next();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic idle_c();
    c_req_i = 1'b0; c_we_i = 1'b0; c_addr_i = '0; c_din_i = '0;
  endtask

  task automatic idle_a();
    a_req_i = 1'b0; a_we_i = 1'b0; a_addr_i = '0; a_din_i = '0;
  endtask

  initial begin
    logic              cg, ag;
    logic [ADDR_W-1:0] addr;

    for (int i = 0; i < 512; i++) begin
      mem[i]    = 32'hA500_0000 | i;
      shadow[i] = 32'hA500_0000 | i;
    end
    mem[9'h010] = 32'hDEAD_BEEF; shadow[9'h010] = 32'hDEAD_BEEF;
    mem[9'h001] = 32'h1111_1111; shadow[9'h001] = 32'h1111_1111;
    mem[9'h002] = 32'h2222_2222; shadow[9'h002] = 32'h2222_2222;

    rst = 1'b1;
    idle_c();
    idle_a();
    repeat (3) @(posedge clk);
    samp();
    chk("reset_c_rvalid", 32'(c_rvalid_o), 32'd0);
    chk("reset_a_rvalid", 32'(a_rvalid_o), 32'd0);
    drive_next();
    rst = 1'b0;
    samp();
    chk("idle_gnt", 32'({c_gnt_o, a_gnt_o, mem_we_o}), 32'd0);

    // Single core read with fixed two-cycle return.
    drive_next();
    c_req_i = 1'b1; c_addr_i = 9'h010;
    samp();
    chk("t1_c_gnt", 32'(c_gnt_o), 32'd1);
    chk("t1_a_gnt", 32'(a_gnt_o), 32'd0);
    drive_next();
    idle_c();
    samp();
    chk("t1_rvalid_early", 32'(c_rvalid_o), 32'd0);
    samp();
    chk("t1_rvalid", 32'(c_rvalid_o), 32'd1);
    chk("t1_dout", c_dout_o, 32'hDEAD_BEEF);
    chk("t1_a_rvalid", 32'(a_rvalid_o), 32'd0);
    samp();
    chk("t1_rvalid_late", 32'(c_rvalid_o), 32'd0);

    // Simultaneous requests: C first, A on the following cycle.
    drive_next();
    c_req_i = 1'b1; c_addr_i = 9'h001;
    a_req_i = 1'b1; a_addr_i = 9'h002;
    samp();
    chk("t2_c_gnt", 32'(c_gnt_o), 32'd1);
    chk("t2_a_wait", 32'(a_gnt_o), 32'd0);
    drive_next();
    idle_c();
    samp();
    chk("t2_a_gnt", 32'(a_gnt_o), 32'd1);
    drive_next();
    idle_a();
    samp();
    chk("t2_c_rvalid", 32'(c_rvalid_o), 32'd1);
    chk("t2_c_dout", c_dout_o, 32'h1111_1111);
    samp();
    chk("t2_a_rvalid", 32'(a_rvalid_o), 32'd1);
    chk("t2_a_dout", a_dout_o, 32'h2222_2222);
    chk("t2_c_quiet", 32'(c_rvalid_o), 32'd0);

    // Starvation: C requests every cycle, A must win on the 9th.
    drive_next();
    drive_next();
    c_req_i = 1'b1; c_addr_i = 9'h030;
    a_req_i = 1'b1; a_addr_i = 9'h020;
    for (int k = 1; k <= 12; k++) begin
      samp();
      ag = a_gnt_o;
      chk($sformatf("t3_a_gnt_%0d", k), 32'(a_gnt_o), 32'(k == 9));
      chk($sformatf("t3_c_gnt_%0d", k), 32'(c_gnt_o), 32'(k != 9));
      drive_next();
      if (ag) idle_a();
      c_addr_i = c_addr_i + 1'b1;
    end
    idle_c();

    // Write then read of the top address, then a wrapping read burst.
    drive_next();
    c_req_i = 1'b1; c_we_i = 1'b1; c_addr_i = 9'h1FF; c_din_i = 32'h1234_5678;
    samp();
    chk("t4_wr_gnt", 32'({c_gnt_o, mem_we_o}), 32'd3);
    drive_next();
    c_we_i = 1'b0; c_din_i = '0;
    samp();
    chk("t4_rd_gnt", 32'({c_gnt_o, mem_we_o}), 32'd2);
    drive_next();
    idle_c();
    samp();
    samp();
    chk("t4_rvalid", 32'(c_rvalid_o), 32'd1);
    chk("t4_dout", c_dout_o, 32'h1234_5678);
    addr = 9'h1FE;
    for (int k = 0; k < 4; k++) begin
      drive_next();
      c_req_i = 1'b1; c_addr_i = addr;
      addr = addr + 1'b1;
      samp();
      chk($sformatf("t4_burst_gnt_%0d", k), 32'(c_gnt_o), 32'd1);
    end
    drive_next();
    idle_c();
    repeat (3) drive_next();

    // Reset with a read in flight drops it.
    c_req_i = 1'b1; c_addr_i = 9'h010;
    samp();
    chk("t5_c_gnt", 32'(c_gnt_o), 32'd1);
    drive_next();
    rst = 1'b1;
    idle_c();
    a_req_i = 1'b1; a_addr_i = 9'h002;
    samp();
    chk("t5_rst_gnt", 32'({c_gnt_o, a_gnt_o, mem_we_o}), 32'd0);
    drive_next();
    samp();
    chk("t5_drop_c", 32'(c_rvalid_o), 32'd0);
    chk("t5_drop_a", 32'(a_rvalid_o), 32'd0);
    drive_next();
    rst = 1'b0;
    samp();
    chk("t5_post_a_gnt", 32'(a_gnt_o), 32'd1);
    chk("t5_post_rvalid", 32'({c_rvalid_o, a_rvalid_o}), 32'd0);
    drive_next();
    idle_a();
    c_req_i = 1'b1; c_addr_i = 9'h010;
    samp();
    chk("t5_read_gnt", 32'(c_gnt_o), 32'd1);
    drive_next();
    idle_c();
    repeat (4) drive_next();

    // Random mixed traffic; each requester holds its request until granted.
    for (int i = 0; i < 400; i++) begin
      samp();
      cg = c_gnt_o;
      ag = a_gnt_o;
      drive_next();
      if (cg || !c_req_i) begin
        c_req_i  = ($urandom_range(0, 3) != 0);
        c_we_i   = 1'($urandom_range(0, 1));
        c_addr_i = ADDR_W'($urandom_range(0, 15));
        c_din_i  = $urandom;
      end
      if (ag || !a_req_i) begin
        a_req_i  = ($urandom_range(0, 1) != 0);
        a_we_i   = 1'($urandom_range(0, 1));
        a_addr_i = ADDR_W'($urandom_range(0, 15));
        a_din_i  = $urandom;
      end
    end
    idle_c();
    idle_a();
    repeat (6) drive_next();
    samp();
    chk("drain_c", 32'(cq.size()), 32'd0);
    chk("drain_a", 32'(aq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
